// File: rtl/reg_writeback.sv
`default_nettype none
// ============================================================================
// Module   : reg_writeback
// Brief    : Merges ALU and long-latency results into the register-file write
//            port, buffering long-latency results and tracking pending writes.
// Revision : 1.0 - initial release
// ============================================================================
module reg_writeback #(
    parameter int LU_FIFO_DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             issue_valid,
    input  logic [4:0]                       issue_rd,
    output logic [31:0]                      busy,
    input  logic                             alu_valid,
    input  logic [4:0]                       alu_rd,
    input  logic [31:0]                      alu_data,
    input  logic                             lu_valid,
    output logic                             lu_ready,
    input  logic [4:0]                       lu_rd,
    input  logic [31:0]                      lu_data,
    output logic                             reg_wren,
    output logic [4:0]                       write_address,
    output logic [31:0]                      write_data,
    output logic [$clog2(LU_FIFO_DEPTH):0]   lu_count
);

    localparam int c_PTR_W = $clog2(LU_FIFO_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(LU_FIFO_DEPTH);

    logic [36:0]        r_mem [LU_FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;

    logic               r_wren;
    logic               r_from_lu;
    logic [4:0]         r_addr;
    logic [31:0]        r_data;
    logic [31:0]        r_busy;

    logic               w_push;
    logic               w_pop;
    logic [36:0]        w_head;
    logic [31:0]        w_busy_set;
    logic [31:0]        w_busy_clr;

    // Ready comes from stored occupancy only, so a same-cycle pop cannot
    // open a slot for a push in that cycle.
    assign lu_ready = (r_count < c_FULL);
    assign w_push   = lu_valid && lu_ready;
    assign w_pop    = !alu_valid && (r_count != '0);
    assign w_head   = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {lu_rd, lu_data};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + c_CNT_W'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - c_CNT_W'(1);
            end
        end
    end

    // x0 destinations still occupy a slot and are popped, but never write.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wren    <= 1'b0;
            r_from_lu <= 1'b0;
            r_addr    <= '0;
            r_data    <= '0;
        end else if (alu_valid) begin
            r_wren    <= (alu_rd != 5'd0);
            r_from_lu <= 1'b0;
            r_addr    <= alu_rd;
            r_data    <= alu_data;
        end else if (w_pop) begin
            r_wren    <= (w_head[36:32] != 5'd0);
            r_from_lu <= 1'b1;
            r_addr    <= w_head[36:32];
            r_data    <= w_head[31:0];
        end else begin
            r_wren    <= 1'b0;
            r_from_lu <= 1'b0;
        end
    end

    // Clear happens on the edge the register file captures the LU write;
    // applying set after clear lets a re-issue to the same register win.
    assign w_busy_clr = (r_wren && r_from_lu) ? (32'd1 << r_addr) : 32'd0;
    assign w_busy_set = (issue_valid && (issue_rd != 5'd0)) ? (32'd1 << issue_rd) : 32'd0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_busy <= '0;
        end else begin
            r_busy <= ((r_busy & ~w_busy_clr) | w_busy_set) & ~32'd1;
        end
    end

    assign busy          = r_busy;
    assign reg_wren      = r_wren;
    assign write_address = r_addr;
    assign write_data    = r_data;
    assign lu_count      = r_count;

endmodule
`default_nettype wire

// File: tb/tb_reg_writeback.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_writeback
// Brief    : Scoreboard bench for reg_writeback against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_writeback;

    localparam int DEPTH = 4;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        issue_valid = 1'b0;
    logic [4:0]  issue_rd = '0;
    logic [31:0] busy;
    logic        alu_valid = 1'b0;
    logic [4:0]  alu_rd = '0;
    logic [31:0] alu_data = '0;
    logic        lu_valid = 1'b0;
    logic        lu_ready;
    logic [4:0]  lu_rd = '0;
    logic [31:0] lu_data = '0;
    logic        reg_wren;
    logic [4:0]  write_address;
    logic [31:0] write_data;
    logic [$clog2(DEPTH):0] lu_count;

    int checks = 0;
    int failures = 0;

    // Reference model: pending LU results, outstanding destinations, and the
    // write currently presented to the register file.
    wr_t         m_fifo[$];
    wr_t         exp_q[$];
    logic [31:0] m_busy = '0;
    logic        m_out_v = 1'b0;
    logic        m_out_lu = 1'b0;
    logic [4:0]  m_out_rd = '0;

    reg_writeback #(.LU_FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .busy(busy),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_rd(lu_rd), .lu_data(lu_data),
        .reg_wren(reg_wren), .write_address(write_address), .write_data(write_data),
        .lu_count(lu_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic model_clear();
        m_fifo.delete();
        exp_q.delete();
        m_busy   = '0;
        m_out_v  = 1'b0;
        m_out_lu = 1'b0;
        m_out_rd = '0;
    endtask

    // One clock cycle: drive inputs, advance the model, then compare the
    // registered state shortly after the edge.
    task automatic step(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                        input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                        input logic iv, input logic [4:0] ird);
        logic        acc;
        logic        nv;
        logic        nlu;
        logic [4:0]  nrd;
        logic [31:0] nd;
        wr_t         e;
        alu_valid = av; alu_rd = ard; alu_data = ad;
        lu_valid = lv;  lu_rd = lrd;  lu_data = ld;
        issue_valid = iv; issue_rd = ird;
        acc = lv && (m_fifo.size() < DEPTH);
        nv = 1'b0; nlu = 1'b0; nrd = '0; nd = '0;
        if (av) begin
            nv = 1'b1; nrd = ard; nd = ad;
        end else if (m_fifo.size() != 0) begin
            e = m_fifo.pop_front();
            nv = 1'b1; nlu = 1'b1; nrd = e.rd; nd = e.data;
        end
        if (m_out_v && m_out_lu && m_out_rd != 5'd0) m_busy[m_out_rd] = 1'b0;
        if (iv && ird != 5'd0) m_busy[ird] = 1'b1;
        if (acc) m_fifo.push_back('{lrd, ld});
        m_out_v = nv; m_out_lu = nlu; m_out_rd = nrd;
        @(posedge clk);
        if (nv && nrd != 5'd0) exp_q.push_back('{nrd, nd});
        #1;
        chk("lu_count", 32'(lu_count), 32'(m_fifo.size()));
        chk("lu_ready", 32'(lu_ready), 32'(m_fifo.size() < DEPTH));
        chk("busy", busy, m_busy);
    endtask

    task automatic idle();
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    endtask

    // Monitor: exactly one expected write must be presented per write cycle.
    always @(negedge clk) begin : monitor
        wr_t e;
        if (reset_n) begin
            if (reg_wren) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", 32'(reg_wren), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("write_address", 32'(write_address), 32'(e.rd));
                    chk("write_data", write_data, e.data);
                end
            end else if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("missing_write", 32'(reg_wren), 32'd1);
            end
        end
    end

    initial begin
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wren", 32'(reg_wren), 32'd0);
        chk("rst_ready", 32'(lu_ready), 32'd1);
        chk("rst_count", 32'(lu_count), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Idle after reset: outputs stay at zero.
        for (int i = 0; i < 10; i++) begin
            idle();
            chk("idle_wren", 32'(reg_wren), 32'd0);
            chk("idle_addr", 32'(write_address), 32'd0);
            chk("idle_data", write_data, 32'd0);
        end

        // Single ALU write.
        step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        chk("alu_wren", 32'(reg_wren), 32'd1);
        chk("alu_addr", 32'(write_address), 32'd5);
        chk("alu_data", write_data, 32'hDEADBEEF);
        idle();
        chk("alu_wren_off", 32'(reg_wren), 32'd0);

        // Scoreboard round trip for x10, then an issue to x0.
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd10);
        chk("busy10_set", 32'(busy[10]), 32'd1);
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd10, 32'h1234, 1'b0, 5'd0);
        chk("lu_accept_no_write", 32'(reg_wren), 32'd0);
        idle();
        chk("lu_wren", 32'(reg_wren), 32'd1);
        chk("lu_addr", 32'(write_address), 32'd10);
        chk("busy10_held", 32'(busy[10]), 32'd1);
        idle();
        chk("busy10_clr", 32'(busy[10]), 32'd0);
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0);
        chk("busy_x0", busy, 32'd0);

        // Back-pressure under continuous ALU traffic, then drain.
        for (int i = 0; i < 5; i++)
            step(1'b1, 5'(i + 1), $urandom, 1'b1, 5'(i + 20), 32'h100 + 32'(i), 1'b0, 5'd0);
        chk("full_count", 32'(lu_count), 32'd4);
        chk("full_ready", 32'(lu_ready), 32'd0);
        idle();
        chk("drain_ready", 32'(lu_ready), 32'd1);
        // Push while popping keeps occupancy constant.
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd30, 32'h55, 1'b0, 5'd0);
        chk("pushpop_count", 32'(lu_count), 32'd3);
        repeat (5) idle();

        // Re-issue to x7 on its commit edge keeps busy set.
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7);
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h77, 1'b0, 5'd0);
        idle();
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7);
        chk("busy7_reissue", 32'(busy[7]), 32'd1);

        // LU result to x0 is popped without writing.
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h99, 1'b0, 5'd0);
        idle();
        chk("x0_lu_wren", 32'(reg_wren), 32'd0);
        chk("x0_lu_count", 32'(lu_count), 32'd0);

        // Mid-operation reset with three queued results and busy = 0x480.
        step(1'b1, 5'd1, 32'd1, 1'b1, 5'd2, 32'd2, 1'b1, 5'd10);
        step(1'b1, 5'd1, 32'd1, 1'b1, 5'd3, 32'd3, 1'b0, 5'd0);
        step(1'b1, 5'd1, 32'd1, 1'b1, 5'd4, 32'd4, 1'b0, 5'd0);
        chk("pre_rst_busy", busy, 32'h0000_0480);
        chk("pre_rst_count", 32'(lu_count), 32'd3);
        #2;
        reset_n = 1'b0;
        alu_valid = 1'b0; lu_valid = 1'b0; issue_valid = 1'b0;
        #1;
        model_clear();
        chk("mid_rst_wren", 32'(reg_wren), 32'd0);
        chk("mid_rst_busy", busy, 32'd0);
        chk("mid_rst_count", 32'(lu_count), 32'd0);
        chk("mid_rst_addr", 32'(write_address), 32'd0);
        chk("mid_rst_data", write_data, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (6) idle();

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            step(($urandom % 3) == 0, 5'($urandom), $urandom,
                 ($urandom % 2) == 0, 5'($urandom), $urandom,
                 ($urandom % 4) == 0, 5'($urandom));
        end
        repeat (8) idle();
        @(negedge clk);
        #1;
        chk("exp_q_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/reg_writeback.md
# reg_writeback

Write-side controller for the 32×32 integer register file. It merges results from the single-cycle ALU and the long-latency unit (load/divide/FPU-to-int) into the file's single write port. Results are registered before they reach `reg_wren`/`write_address`/`write_data`. It keeps a pending-destination scoreboard, and issue/hazard logic reads that scoreboard before using read ports 1/2.

## Interface
Parameters:
- `LU_FIFO_DEPTH`, default 4: entries in the long-latency result FIFO; power of two, 2..16.

Ports:
- `clk` in 1: single clock; all state updates on rising edge.
- `reset_n` in 1: reset, asynchronous, active-low.
- `issue_valid` in 1: a long-latency instruction that will write `issue_rd` issues this cycle.
- `issue_rd` in 5: destination of the issuing long-latency instruction.
- `busy` out 32: scoreboard; bit k=1 means a long-latency write to xk is outstanding; bit 0 is constant 0.
- `alu_valid` in 1: ALU result present; always accepted, no ready.
- `alu_rd` in 5: ALU destination.
- `alu_data` in 32: ALU result.
- `lu_valid` in 1: long-latency result offered.
- `lu_ready` out 1: FIFO can accept; transfer when `lu_valid && lu_ready`.
- `lu_rd` in 5: long-latency destination.
- `lu_data` in 32: long-latency result.
- `reg_wren` out 1: register-file write enable (registered).
- `write_address` out 5: register-file write address (registered).
- `write_data` out 32: register-file write data (registered).
- `lu_count` out clog2(DEPTH)+1: current FIFO occupancy.

## Operation
- LU FIFO: circular buffer of {rd, data}. Pointers wrap modulo DEPTH. `lu_ready = (lu_count < DEPTH)`; it depends only on stored count, not on a same-cycle pop.
- Per-cycle arbitration into the output register:
  - `alu_valid=1`: load ALU {rd, data}; FIFO not popped.
  - Else if FIFO non-empty: pop head and load it; the source flag `from_lu` is registered alongside.
  - Else `reg_wren` is 0 next cycle.
- Destination x0: the write is selected and popped as normal, but `reg_wren` is driven 0 for that slot and x0 is never marked busy.
- The FIFO may push and pop in the same cycle; `lu_count` is unchanged in that case.
- Scoreboard, on each edge:
  - Set `busy[issue_rd]` when `issue_valid` and `issue_rd != 0`.
  - Clear `busy[write_address]` when the output register holds a committed LU write (`reg_wren && from_lu`), i.e. on the same edge the register file captures it.
  - Same register set and cleared on one edge: set wins.
- ALU writes never touch the scoreboard. Issue logic guarantees no ALU write targets a busy register.
- Starvation of the FIFO under continuous `alu_valid` is permitted; upstream back-pressures via `lu_ready`.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert by upstream):
  - `reg_wren=0`, `write_address=0`, `write_data=0`, `busy=0`, `lu_count=0`, `lu_ready=1`, `from_lu=0`.
  - Pointers are cleared; FIFO contents are don't-care.
- Reset mid-operation drops all queued results and pending busy bits immediately.
- ALU path: `alu_valid` sampled at edge N, `reg_wren`/address/data valid after edge N, register file updated at edge N+1.
- LU path: accepted at edge N, earliest output after edge N+1 (if no ALU that cycle), register file and busy-clear at edge N+2.
- Full FIFO: `lu_ready=0` for the whole cycle. A pop that cycle raises `lu_ready` only after the edge.
- Outputs change only on `clk` edges or `reset_n` assertion; no combinational path from inputs to outputs except none (`lu_ready` is from registered count).

## Test plan
- Reset then idle: all outputs 0, `lu_ready=1`. Hold for 10 cycles; outputs remain 0.
- ALU write: `alu_valid=1`, `alu_rd=5`, `alu_data=32'hDEADBEEF` for one cycle. Next cycle `reg_wren=1`, `write_address=5`, `write_data=32'hDEADBEEF`; the cycle after that `reg_wren=0`.
- Scoreboard round trip: issue `issue_rd=10`, so `busy[10]=1`. Offer LU {10, 32'h1234}. The write appears 2 edges after acceptance and `busy[10]` clears at the commit edge. An issue to x0 leaves `busy=0`.
- Priority/back-pressure:
  - Hold `alu_valid=1` continuously and push 4 LU results: `lu_count=4`, `lu_ready=0`, and the 5th offer stalls.
  - Drop `alu_valid`: the FIFO drains in order, one per cycle, and `lu_ready` returns to 1 after the first pop.
- Simultaneous events:
  - Same-cycle push and pop keeps `lu_count` constant.
  - Re-issue to x7 on the edge its prior LU write commits leaves `busy[7]=1`.
  - An LU result to x0 produces `reg_wren=0` and is popped.
- Mid-operation reset: assert `reset_n=0` with 3 queued entries and `busy=32'h0000_0480`. All outputs go to 0 immediately, and no writes occur after release.
